// File: rtl/bu2point_inv.sv
// Inverse (Gentleman-Sande) radix-2 modular butterfly: B0 = A0+A1 mod q, B1 = (A0-A1)*Y mod q,
// optionally both scaled by 2^-1 mod q. Iterative MSB-first multiplier behind valid/ready handshakes.
module bu2point_inv #(
  parameter int unsigned BIT_SIZE = 60,
  parameter bit          HALVE    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] A0,
  input  logic [BIT_SIZE-1:0] A1,
  input  logic [BIT_SIZE-1:0] Y,
  input  logic [BIT_SIZE-1:0] q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] B0,
  output logic [BIT_SIZE-1:0] B1
);

  localparam int unsigned W1    = BIT_SIZE + 1;
  localparam int unsigned CNT_W = $clog2(BIT_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_MUL,
    S_HALF,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [BIT_SIZE-1:0] a0_r, a1_r, y_r, q_r;
  logic [BIT_SIZE-1:0] a0_nxt, a1_nxt, y_nxt, q_nxt;
  logic [W1-1:0]       s_r, d_r, acc_r;
  logic [W1-1:0]       s_nxt, d_nxt, acc_nxt;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt;
  logic                in_ready_nxt, out_valid_nxt;
  logic [BIT_SIZE-1:0] b0_nxt, b1_nxt;

  // x * 2^-1 mod m for x < m, m odd: an odd x is made even by adding m first
  function automatic logic [W1-1:0] halve_mod(input logic [W1-1:0] x, input logic [W1-1:0] m);
    logic [W1-1:0] t;
    t = x[0] ? (x + m) : x;
    return t >> 1;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      a0_r      <= '0;
      a1_r      <= '0;
      y_r       <= '0;
      q_r       <= '0;
      s_r       <= '0;
      d_r       <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      B0        <= '0;
      B1        <= '0;
    end else begin
      state     <= state_nxt;
      a0_r      <= a0_nxt;
      a1_r      <= a1_nxt;
      y_r       <= y_nxt;
      q_r       <= q_nxt;
      s_r       <= s_nxt;
      d_r       <= d_nxt;
      acc_r     <= acc_nxt;
      cnt_r     <= cnt_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      B0        <= b0_nxt;
      B1        <= b1_nxt;
    end
  end

  // Next-state and datapath
  always_comb begin
    logic [W1-1:0] qw, sum, dif, dbl, dbl_red, add, add_red;

    state_nxt     = state;
    a0_nxt        = a0_r;
    a1_nxt        = a1_r;
    y_nxt         = y_r;
    q_nxt         = q_r;
    s_nxt         = s_r;
    d_nxt         = d_r;
    acc_nxt       = acc_r;
    cnt_nxt       = cnt_r;
    out_valid_nxt = out_valid;
    b0_nxt        = B0;
    b1_nxt        = B1;

    qw      = W1'(q_r);
    sum     = W1'(a0_r) + W1'(a1_r);
    dif     = W1'(a0_r) - W1'(a1_r);
    dbl     = {acc_r[W1-2:0], 1'b0};
    dbl_red = (dbl >= qw) ? (dbl - qw) : dbl;
    add     = dbl_red + d_r;
    add_red = (add >= qw) ? (add - qw) : add;

    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a0_nxt    = A0;
          a1_nxt    = A1;
          y_nxt     = Y;
          q_nxt     = q;
          state_nxt = S_PREP;
        end
      end
      S_PREP: begin
        s_nxt     = (sum >= qw) ? (sum - qw) : sum;
        d_nxt     = (a0_r < a1_r) ? (dif + qw) : dif;
        acc_nxt   = '0;
        cnt_nxt   = CNT_W'(BIT_SIZE - 1);
        state_nxt = S_MUL;
      end
      S_MUL: begin
        acc_nxt = y_r[cnt_r] ? add_red : dbl_red;
        cnt_nxt = cnt_r - CNT_W'(1);
        if (cnt_r == '0) begin
          if (HALVE) begin
            state_nxt = S_HALF;
          end else begin
            b0_nxt        = BIT_SIZE'(s_r);
            b1_nxt        = BIT_SIZE'(acc_nxt);
            out_valid_nxt = 1'b1;
            state_nxt     = S_DONE;
          end
        end
      end
      S_HALF: begin
        b0_nxt        = BIT_SIZE'(halve_mod(s_r, qw));
        b1_nxt        = BIT_SIZE'(halve_mod(acc_r, qw));
        out_valid_nxt = 1'b1;
        state_nxt     = S_DONE;
      end
      S_DONE: begin
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    in_ready_nxt = (state_nxt == S_IDLE);
  end

endmodule

// File: tb/tb_bu2point_inv.sv
// Self-checking bench for bu2point_inv: one instance per HALVE setting, directed and random
// operand sets checked against a wide-arithmetic modular reference model.
module tb_bu2point_inv;

  localparam int unsigned BS = 60;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BS-1:0] a0 = '0, a1 = '0, y = '0, qv = 60'd9001;
  logic          iv0 = 1'b0, iv1 = 1'b0, or0 = 1'b0, or1 = 1'b0;
  logic          ir0, ir1, ov0, ov1;
  logic [BS-1:0] b0_0, b1_0, b0_1, b1_1;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit rec        = 1'b0;
  int hs_q[$];

  bu2point_inv #(.BIT_SIZE(BS), .HALVE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .A0(a0), .A1(a1), .Y(y), .q(qv),
    .out_valid(ov0), .out_ready(or0), .B0(b0_0), .B1(b1_0)
  );

  bu2point_inv #(.BIT_SIZE(BS), .HALVE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .A0(a0), .A1(a1), .Y(y), .q(qv),
    .out_valid(ov1), .out_ready(or1), .B0(b0_1), .B1(b1_1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rec && iv0 && ir0) hs_q.push_back(cyc);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic on 128-bit values; halving is a multiply by (q+1)/2
  function automatic void ref_bfly(input bit h, input logic [BS-1:0] ia0, ia1, iy, iq,
                                   output logic [BS-1:0] e0, output logic [BS-1:0] e1);
    logic [127:0] m, s, d, p, inv2;
    m = 128'(iq);
    s = (128'(ia0) + 128'(ia1)) % m;
    d = (128'(ia0) + m - 128'(ia1)) % m;
    p = (d * 128'(iy)) % m;
    if (h) begin
      inv2 = (m + 128'd1) / 128'd2;
      s = (s * inv2) % m;
      p = (p * inv2) % m;
    end
    e0 = BS'(s);
    e1 = BS'(p);
  endfunction

  function automatic logic [BS-1:0] rnd_q();
    logic [BS-1:0] r;
    r = BS'({$urandom, $urandom}) & {1'b0, {(BS-1){1'b1}}};
    r[0] = 1'b1;
    if (r < 3) r = 60'd3;
    return r;
  endfunction

  function automatic logic [BS-1:0] rnd_below(input logic [BS-1:0] m);
    return BS'(128'({$urandom, $urandom}) % 128'(m));
  endfunction

  task automatic start_op(input bit h, input logic [BS-1:0] ia0, ia1, iy, iq);
    @(negedge clk);
    a0 = ia0; a1 = ia1; y = iy; qv = iq;
    check(h ? "in_ready1_idle" : "in_ready0_idle", 128'(h ? ir1 : ir0), 128'd1);
    if (h) iv1 = 1'b1; else iv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0; iv1 = 1'b0;
  endtask

  task automatic wait_result(input bit h, input logic [BS-1:0] e0, e1, input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!(h ? ov1 : ov0) && lat < 200);
    check({tag, "_latency"}, 128'(lat), 128'(BS + 1 + int'(h)));
    check({tag, "_B0"}, 128'(h ? b0_1 : b0_0), 128'(e0));
    check({tag, "_B1"}, 128'(h ? b1_1 : b1_0), 128'(e1));
  endtask

  task automatic finish_op(input bit h);
    if (h) or1 = 1'b1; else or0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("out_valid_drop", 128'(h ? ov1 : ov0), 128'd0);
    check("in_ready_return", 128'(h ? ir1 : ir0), 128'd1);
    or0 = 1'b0; or1 = 1'b0;
  endtask

  task automatic full_op(input bit h, input logic [BS-1:0] ia0, ia1, iy, iq, input string tag);
    logic [BS-1:0] e0, e1;
    ref_bfly(h, ia0, ia1, iy, iq, e0, e1);
    start_op(h, ia0, ia1, iy, iq);
    wait_result(h, e0, e1, tag);
    finish_op(h);
  endtask

  initial begin
    logic [BS-1:0] e0, e1, s0, s1, rq;
    logic [BS-1:0] ops[4][4];
    int lat;

    // Reset state
    #12;
    check("rst_in_ready", 128'(ir0), 128'd1);
    check("rst_out_valid", 128'(ov0), 128'd0);
    check("rst_B0", 128'(b0_0), 128'd0);
    check("rst_B1", 128'(b1_0), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases, both halving modes
    full_op(1'b0, 60'd5000, 60'd7000, 60'd3000, 60'd9001, "case1");
    check("case1_B0_const", 128'(b0_0), 128'd2999);
    check("case1_B1_const", 128'(b1_0), 128'd3667);
    full_op(1'b1, 60'd5000, 60'd7000, 60'd3000, 60'd9001, "case2");
    check("case2_B0_const", 128'(b0_1), 128'd6000);
    check("case2_B1_const", 128'(b1_1), 128'd6334);
    full_op(1'b0, 60'd1, 60'd0, 60'd9000, 60'd9001, "case3a");
    full_op(1'b0, 60'd4500, 60'd4501, 60'd5, 60'd9001, "case3b");
    full_op(1'b0, 60'd1234, 60'd1234, 60'd777, 60'd9001, "case3c");
    full_op(1'b1, 60'd4500, 60'd4501, 60'd0, 60'd9001, "halve_y0");

    // Random operand sets with wide odd moduli
    for (int i = 0; i < 6; i++) begin
      rq = rnd_q();
      full_op(1'(i % 2), rnd_below(rq), rnd_below(rq), rnd_below(rq), rq, "random");
    end
    rq = rnd_q();
    full_op(1'b0, rq - 60'd1, rq - 60'd1, rq - 60'd1, rq, "max_operands");

    // Back-pressure: results held, in_ready low, new in_valid ignored
    ref_bfly(1'b0, 60'd77, 60'd9000, 60'd4321, 60'd9001, e0, e1);
    start_op(1'b0, 60'd77, 60'd9000, 60'd4321, 60'd9001);
    wait_result(1'b0, e0, e1, "bp");
    s0 = b0_0; s1 = b1_0;
    a0 = 60'd1; a1 = 60'd2; y = 60'd3; iv0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 128'(ov0), 128'd1);
      check("bp_B0_hold", 128'(b0_0), 128'(s0));
      check("bp_B1_hold", 128'(b1_0), 128'(s1));
      check("bp_in_ready", 128'(ir0), 128'd0);
    end
    iv0 = 1'b0;
    finish_op(1'b0);

    // Asynchronous reset mid-multiply, then a clean operation
    start_op(1'b0, 60'd5000, 60'd7000, 60'd3000, 60'd9001);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 128'(ov0), 128'd0);
    check("arst_B0", 128'(b0_0), 128'd0);
    check("arst_B1", 128'(b1_0), 128'd0);
    check("arst_in_ready", 128'(ir0), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    full_op(1'b0, 60'd5000, 60'd7000, 60'd3000, 60'd9001, "after_rst");

    // Back-to-back with in_valid and out_ready held high
    rq = rnd_q();
    for (int i = 0; i < 4; i++) begin
      ops[i][0] = rnd_below(rq); ops[i][1] = rnd_below(rq);
      ops[i][2] = rnd_below(rq); ops[i][3] = rq;
    end
    hs_q.delete();
    rec = 1'b1;
    @(negedge clk);
    or0 = 1'b1;
    a0 = ops[0][0]; a1 = ops[0][1]; y = ops[0][2]; qv = ops[0][3];
    iv0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ref_bfly(1'b0, ops[i][0], ops[i][1], ops[i][2], ops[i][3], e0, e1);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!ov0 && lat < 200);
      check("b2b_timeout", 128'(lat < 200), 128'd1);
      check("b2b_B0", 128'(b0_0), 128'(e0));
      check("b2b_B1", 128'(b1_0), 128'(e1));
      if (i < 3) begin
        a0 = ops[i+1][0]; a1 = ops[i+1][1]; y = ops[i+1][2]; qv = ops[i+1][3];
      end else begin
        iv0 = 1'b0;
      end
    end
    @(negedge clk);
    rec = 1'b0;
    or0 = 1'b0;
    check("b2b_handshakes", 128'(hs_q.size()), 128'd4);
    for (int i = 1; i < hs_q.size(); i++)
      check("b2b_period", 128'(hs_q[i] - hs_q[i-1]), 128'd63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bu2point_inv.md
Name: bu2point_inv

Overview:
- Inverse (Gentleman-Sande) radix-2 modular butterfly. It is the decimation-in-frequency counterpart of the forward Cooley-Tukey butterfly used in the NTT datapath.
- Computes B0 = (A0 + A1) mod q and B1 = ((A0 - A1) * Y) mod q.
- Optional halving by 2^-1 mod q supports the final INTT scaling stage.
- Multi-cycle: an iterative MSB-first interleaved modular multiplier with a valid/ready handshake on both sides, so it can share pipeline slots in the INTT controller.

Parameters:
- BIT_SIZE, 60, width of operands, modulus and results.
- HALVE, 0, when 1 both outputs are multiplied by 2^-1 mod q before being presented.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands. High only in IDLE.
- A0  input  BIT_SIZE  even-index input, in the range [0, q).
- A1  input  BIT_SIZE  odd-index input, in the range [0, q).
- Y  input  BIT_SIZE  inverse twiddle factor, in the range [0, q).
- q  input  BIT_SIZE  modulus. Must be odd, with 3 <= q < 2^(BIT_SIZE-1).
- out_valid  output  1  B0/B1 valid.
- out_ready  input  1  downstream accepts results.
- B0  output  BIT_SIZE  sum result.
- B1  output  BIT_SIZE  difference-times-twiddle result.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, in_ready=1, out_valid=0, B0=0, B1=0, and all internal registers are cleared. A reset mid-operation aborts the operation immediately. No output is produced for the aborted operand set.
- State machine: IDLE -> PREP -> MUL -> (HALF if HALVE=1) -> DONE -> IDLE.
- IDLE:
  - On in_valid & in_ready at edge k, register A0, A1, Y and q, then go to PREP.
- PREP (edge k+1):
  - s = A0 + A1; if s >= q then s = s - q.
  - d = A0 - A1; if negative then d = d + q.
  - Register s and d, clear acc, set bit counter = BIT_SIZE-1, go to MUL.
- MUL (edges k+2 .. k+1+BIT_SIZE), one twiddle bit per cycle, MSB first:
  - acc = 2*acc; if acc >= q then subtract q.
  - If Y[cnt] = 1: acc = acc + d; if acc >= q then subtract q.
  - Internal width is BIT_SIZE+1, so no intermediate overflows.
  - On cnt = 0, exit MUL.
  - If HALVE=0: load B0=s, B1=acc, set out_valid=1, go to DONE. out_valid rises after edge k+1+BIT_SIZE.
- HALF (HALVE=1 only, edge k+2+BIT_SIZE):
  - For each of s and acc: x even -> x>>1; x odd -> (x+q)>>1.
  - Load B0 and B1 with the halved values, set out_valid=1, go to DONE.
- DONE:
  - B0, B1 and out_valid are held stable while out_ready=0.
  - On out_valid & out_ready: out_valid=0, go to IDLE, and in_ready=1 from the next cycle. B0/B1 keep their last values.
- Latency from input handshake to out_valid: BIT_SIZE+1 cycles for HALVE=0, BIT_SIZE+2 for HALVE=1. No overlap between operations.
- in_valid while not in IDLE is ignored. Operand inputs are only sampled at the accepting edge; later changes have no effect.
- Out-of-range operands (>= q) or an even q give undefined values, but the FSM must still complete and return to IDLE.
- Boundary values:
  - A0 = A1 gives d = 0, so B1 = 0.
  - Y = 0 gives B1 = 0.
  - A0 + A1 = q exactly gives B0 = 0.

Test Plan:
1. HALVE=0, q=9001, A0=5000, A1=7000, Y=3000 -> B0=2999, B1=3667; out_valid is asserted exactly BIT_SIZE+1=61 cycles after the handshake.
2. HALVE=1, same operands -> B0=6000, B1=6334, latency 62 cycles.
3. HALVE=0, q=9001: (A0=1, A1=0, Y=9000) -> B0=1, B1=9000; (A0=4500, A1=4501, Y=5) -> B0=0, B1=8996; (A0=A1=1234, Y=777) -> B0=2468, B1=0.
4. Back-pressure: hold out_ready=0 for 10 cycles after out_valid. B0/B1/out_valid stay stable, in_ready stays 0, and a new in_valid is ignored. out_ready=1 completes the transfer and in_ready returns the next cycle.
5. Reset mid-MUL: assert rst at cycle 20 of an operation. out_valid=0, B0=B1=0 and in_ready=1 immediately (asynchronous). Release rst, then a fresh operation (case 1 operands) returns the correct results.
6. Back-to-back: keep out_ready=1 and in_valid=1 with a new operand set after each completion -> every result is correct, one result per 63 cycles for HALVE=0.
